// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port and a data port. Each transaction runs IDLE -> ACCESS (MEM_LAT cycles)
// -> RESP (1 cycle) -> IDLE. Requests are only looked at in IDLE.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate between the two ports; when undefined, the data port
// always wins a tie.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_data_q, owner_data_d;
  logic        we_q, we_d;
  logic        i_gnt_q, i_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        m_en_q, m_en_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        win_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_data_q, last_data_d;

  // On a tie the port that did not win the previous grant goes next
  always_comb begin
    win_data = d_req;
    if (i_req && d_req) win_data = ~last_data_q;
  end
`else
  // On a tie the data port always wins; fetch may starve
  always_comb begin
    win_data = d_req;
  end
`endif

  // Next-state and next-output logic for the whole transaction sequence
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_data_d = owner_data_q;
    we_d         = we_q;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    i_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    m_en_d       = m_en_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    rdata_d      = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d  = last_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d      = ST_ACCESS;
          cnt_d        = LAT_LOAD;
          owner_data_d = win_data;
          we_d         = win_data & d_we;
          i_gnt_d      = ~win_data;
          d_gnt_d      = win_data;
          m_en_d       = 1'b1;
          m_we_d       = win_data & d_we;
          m_addr_d     = win_data ? d_addr : i_addr;
          m_wdata_d    = win_data ? d_wdata : 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_d  = win_data;
`endif
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd1) begin
          // Last access cycle: memory data is valid now, so capture it
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          rdata_d    = we_q ? 32'd0 : m_rdata;
          m_en_d     = 1'b0;
          m_we_d     = 1'b0;
          i_rvalid_d = ~owner_data_q;
          d_rvalid_d = owner_data_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      m_en_q       <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 32'd0;
      m_wdata_q    <= 32'd0;
      rdata_q      <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_data_q <= owner_data_d;
      we_q         <= we_d;
      i_gnt_q      <= i_gnt_d;
      d_gnt_q      <= d_gnt_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      m_en_q       <= m_en_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      rdata_q      <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q  <= last_data_d;
`endif
    end
  end

  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT = 1, 3, 4) with separate
// stimulus, a transaction-level timing model checked every cycle, and
// directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int N = 3;

  logic        clk;
  logic        rst_n    [N];
  logic        i_req    [N];
  logic [31:0] i_addr   [N];
  logic        i_gnt    [N];
  logic        i_rvalid [N];
  logic        d_req    [N];
  logic        d_we     [N];
  logic [31:0] d_addr   [N];
  logic [31:0] d_wdata  [N];
  logic        d_gnt    [N];
  logic        d_rvalid [N];
  logic [31:0] rdata    [N];
  logic        m_en     [N];
  logic        m_we     [N];
  logic [31:0] m_addr   [N];
  logic [31:0] m_wdata  [N];
  logic [31:0] m_rdata  [N];

  int checks;
  int errors;
  int ecnt;

  // transaction-level model state, one entry per instance
  bit          busy    [N];
  int          t0      [N];
  bit          win_d   [N];
  bit          lwe     [N];
  logic [31:0] laddr   [N];
  logic [31:0] lwdata  [N];
  logic [31:0] rdx     [N];
  bit          last_d  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_arbiter #(.MEM_LAT(L)) u_dut (
      .clk      (clk),
      .reset_n  (rst_n[g]),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_gnt    (i_gnt[g]),
      .i_rvalid (i_rvalid[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .rdata    (rdata[g]),
      .m_en     (m_en[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (m_rdata[g])
    );
  end

  function automatic int lat(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // memory contents: one fixed instruction word, everything else address-derived
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) m_rdata[k] = memval(m_addr[k]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h (edge %0d)", nm, k, act, exp, ecnt);
    end
  endtask

  task automatic chkb(input string nm, input int k, input logic act, input logic exp);
    chk(nm, k, 32'(act), 32'(exp));
  endtask

  task automatic model_clear(input int k);
    busy[k]   = 1'b0;
    t0[k]     = 0;
    win_d[k]  = 1'b0;
    lwe[k]    = 1'b0;
    laddr[k]  = 32'd0;
    lwdata[k] = 32'd0;
    rdx[k]    = 32'd0;
    last_d[k] = 1'b1;
  endtask

  // advance the model across one rising edge (edge index = ecnt)
  task automatic model_update();
    for (int k = 0; k < N; k++) begin
      if (!rst_n[k]) begin
        model_clear(k);
      end else begin
        if (busy[k] && ecnt == t0[k] + lat(k) + 1) begin
          busy[k] = 1'b0;
        end else if (!busy[k] && (i_req[k] || d_req[k])) begin
          if (i_req[k] && d_req[k]) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d[k] = !last_d[k];
`else
            win_d[k] = 1'b1;
`endif
          end else begin
            win_d[k] = d_req[k];
          end
          last_d[k] = win_d[k];
          busy[k]   = 1'b1;
          t0[k]     = ecnt;
          lwe[k]    = win_d[k] && d_we[k];
          laddr[k]  = win_d[k] ? d_addr[k] : i_addr[k];
          lwdata[k] = d_wdata[k];
        end
        if (busy[k] && ecnt == t0[k] + lat(k))
          rdx[k] = lwe[k] ? 32'd0 : memval(laddr[k]);
      end
    end
    ecnt++;
  endtask

  // compare every DUT output against the model for the current cycle
  task automatic compare_all();
    int  dd;
    bit  g, en, rv;
    for (int k = 0; k < N; k++) begin
      dd = (ecnt - 1) - t0[k];
      g  = busy[k] && dd == 0;
      en = busy[k] && dd < lat(k);
      rv = busy[k] && dd == lat(k);
      chkb("i_gnt", k, i_gnt[k], g && !win_d[k]);
      chkb("d_gnt", k, d_gnt[k], g && win_d[k]);
      chkb("i_rvalid", k, i_rvalid[k], rv && !win_d[k]);
      chkb("d_rvalid", k, d_rvalid[k], rv && win_d[k]);
      chkb("m_en", k, m_en[k], en);
      chkb("m_we", k, m_we[k], en && lwe[k]);
      chk("rdata", k, rdata[k], rdx[k]);
      if (en) chk("m_addr", k, m_addr[k], laddr[k]);
      if (en && lwe[k]) chk("m_wdata", k, m_wdata[k], lwdata[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int dg, ig;
    bit expd, expi;
    checks = 0;
    errors = 0;
    ecnt   = 0;
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = 32'd0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
      model_clear(k);
    end
    step();
    step();
    for (int k = 0; k < N; k++) begin
      chkb("rst_m_en", k, m_en[k], 1'b0);
      chk("rst_m_addr", k, m_addr[k], 32'd0);
      chk("rst_m_wdata", k, m_wdata[k], 32'd0);
      chk("rst_rdata", k, rdata[k], 32'd0);
      chkb("rst_gnt", k, i_gnt[k] | d_gnt[k], 1'b0);
      chkb("rst_rvalid", k, i_rvalid[k] | d_rvalid[k], 1'b0);
      rst_n[k] = 1'b1;
    end
    step();

    // single fetch, MEM_LAT=1
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    step();
    chkb("f_i_gnt_c1", 0, i_gnt[0], 1'b1);
    chkb("f_m_en_c1", 0, m_en[0], 1'b1);
    chk("f_m_addr_c1", 0, m_addr[0], 32'h10);
    i_req[0] = 1'b0;
    step();
    chkb("f_i_rvalid_c2", 0, i_rvalid[0], 1'b1);
    chk("f_rdata_c2", 0, rdata[0], 32'h0050_0093);
    chkb("f_m_en_c2", 0, m_en[0], 1'b0);
    step();

    // data write, MEM_LAT=3
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h100; d_wdata[1] = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      chkb("w_d_gnt", 1, d_gnt[1], c == 1);
      if (c == 1) d_req[1] = 1'b0;
      chkb("w_m_en", 1, m_en[1], c <= 3);
      chkb("w_m_we", 1, m_we[1], c <= 3);
      if (c <= 3) chk("w_m_wdata", 1, m_wdata[1], 32'hDEAD_BEEF);
      chkb("w_d_rvalid", 1, d_rvalid[1], c == 4);
    end
    chk("w_rdata", 1, rdata[1], 32'd0);

    // data read raised during RESP: not seen until the following IDLE edge
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h200;
    for (int c = 1; c <= 5; c++) begin
      step();
      chkb("r_d_gnt", 1, d_gnt[1], c == 2);
      if (c == 2) begin
        d_req[1] = 1'b0; d_addr[1] = 32'h300; d_we[1] = 1'b1;
      end
      if (c == 3 || c == 4) chk("r_m_addr_held", 1, m_addr[1], 32'h200);
      chkb("r_d_rvalid", 1, d_rvalid[1], c == 5);
    end
    chk("r_rdata", 1, rdata[1], 32'hA5A5_0200);
    d_we[1] = 1'b0;
    step();

    // simultaneous requests, each dropped on its grant (last grant was fetch)
    i_req[0] = 1'b1; i_addr[0] = 32'h20;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h30;
    dg = -1; ig = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (d_gnt[0]) begin dg = c; d_req[0] = 1'b0; end
      if (i_gnt[0]) begin ig = c; i_req[0] = 1'b0; end
    end
    chk("tie_d_gnt_cycle", 0, 32'(dg), 32'd1);
    chk("tie_i_gnt_cycle", 0, 32'(ig), 32'd4);
    i_req[0] = 1'b0; d_req[0] = 1'b0;

    // both requests held continuously
    i_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
`ifdef ARB_ROUND_ROBIN_EN
      expd = (c == 1 || c == 7);
      expi = (c == 4 || c == 10);
`else
      expd = (c % 3 == 1);
      expi = 1'b0;
`endif
      chkb("held_d_gnt", 0, d_gnt[0], expd);
      chkb("held_i_gnt", 0, i_gnt[0], expi);
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    step();
    step();

    // reset in the second ACCESS cycle, MEM_LAT=4
    i_req[2] = 1'b1; i_addr[2] = 32'h40;
    step();
    chkb("ab_i_gnt_c1", 2, i_gnt[2], 1'b1);
    i_req[2] = 1'b0;
    step();
    chkb("ab_m_en_c2", 2, m_en[2], 1'b1);
    rst_n[2] = 1'b0;
    model_clear(2);
    #1;
    chkb("ab_m_en_async", 2, m_en[2], 1'b0);
    chk("ab_m_addr_async", 2, m_addr[2], 32'd0);
    compare_all();
    for (int c = 1; c <= 3; c++) begin
      step();
      chkb("ab_rvalid_rst", 2, i_rvalid[2], 1'b0);
    end
    rst_n[2] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chkb("ab_rvalid_after", 2, i_rvalid[2], 1'b0);
      chkb("ab_m_en_after", 2, m_en[2], 1'b0);
    end
    i_req[2] = 1'b1; i_addr[2] = 32'h44;
    for (int c = 1; c <= 5; c++) begin
      step();
      chkb("nr_i_gnt", 2, i_gnt[2], c == 1);
      if (c == 1) i_req[2] = 1'b0;
      chkb("nr_m_en", 2, m_en[2], c <= 4);
      chkb("nr_i_rvalid", 2, i_rvalid[2], c == 5);
    end
    chk("nr_rdata", 2, rdata[2], 32'hA5A5_0044);
    step();

    // tie straight after reset: pointer says last grant was data
    rst_n[2] = 1'b0;
    model_clear(2);
    step();
    rst_n[2] = 1'b1;
    step();
    i_req[2] = 1'b1; i_addr[2] = 32'h50;
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h60;
    dg = -1; ig = -1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (d_gnt[2]) begin dg = c; d_req[2] = 1'b0; end
      if (i_gnt[2]) begin ig = c; i_req[2] = 1'b0; end
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("rst_tie_i_cycle", 2, 32'(ig), 32'd1);
    chk("rst_tie_d_cycle", 2, 32'(dg), 32'd7);
`else
    chk("rst_tie_d_cycle", 2, 32'(dg), 32'd1);
    chk("rst_tie_i_cycle", 2, 32'(ig), 32'd7);
`endif
    i_req[2] = 1'b0; d_req[2] = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
